fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage. Holds the PC, issues fetch requests to the memory
//  controller with a ready handshake (wait states allowed), and delivers instruction, PC+4 and
//  valid to decode. Accepts redirects from decode and stalls from execute.
//  Adds over the previous fetch stage: variable-latency memory, in-flight kill on redirect,
//  and a selectable stall mode.
// PARAMETERS
//  ADDR_W      18      memory address width; if_mc_addr = pc[ADDR_W-1:0]
//  RESET_PC    32'd0   PC loaded on reset
//  EXC_VECTOR  32'd64  redirect target for selpctype 2'b11
//  NOP_WORD    32'd0   instruction word driven on a bubble
//  STALL_MODE  1       0: outputs hold during stall; 1: NOP bubble, nextpc = last issued PC
// PORTS
//  clock              in   1       rising-edge clock
//  reset              in   1       asynchronous, active-high reset
//  ex_if_stall        in   1       execute requests stall
//  id_if_selpcsource  in   1       1 = redirect this cycle
//  id_if_selpctype    in   2       00 pcimd2ext, 01 rega, 10 pcindex, 11 EXC_VECTOR
//  id_if_pcimd2ext    in   32      branch target
//  id_if_rega         in   32      register target
//  id_if_pcindex      in   32      jump target
//  if_id_instruc      out  32      fetched instruction (NOP_WORD on bubble)
//  if_id_nextpc       out  32      PC+4 of delivered instruction
//  if_id_valid        out  1       if_id_instruc is a real fetched instruction
//  if_mc_en           out  1       fetch request; held until mc_if_ready
//  if_mc_addr         out  ADDR_W  fetch address, stable while if_mc_en=1
//  mc_if_data         in   32      read data, valid when mc_if_ready=1
//  mc_if_ready        in   1       read complete; may be high the same cycle as if_mc_en
// BEHAVIOUR
//  Reset (async, any state): pc=RESET_PC, pc_last=RESET_PC, state=IDLE, kill=0, hold buffer empty;
//   if_mc_en=0, if_id_instruc=NOP_WORD, if_id_nextpc=0, if_id_valid=0.
//  FSM (registered outputs; if_mc_addr = pc[ADDR_W-1:0] combinational):
//   IDLE : one cycle after reset release; en<=1 -> FETCH.
//   FETCH: en=1. On ready & !kill & !stall: instruc<=data, nextpc<=pc+4, valid<=1,
//          pc_last<=pc, pc<=pc+4, stay FETCH (next addr presented next cycle; 1 instr/cycle peak).
//          On ready & !kill & stall: data -> hold buffer, en<=0 -> HOLD.
//          On ready & kill: data discarded, kill<=0, en stays 1 at new pc.
//          No ready: en and addr held; outputs per bubble/stall rule.
//   HOLD : en=0. When stall drops: deliver buffered word (instruc, nextpc=pc+4, valid=1),
//          pc<=pc+4, en<=1 -> FETCH.
//  Redirect (selpcsource=1, any state except IDLE/reset): pc<=target per selpctype; valid<=0,
//   instruc<=NOP_WORD. If a request is outstanding without ready this cycle: kill<=1, request
//   NOT aborted (memory always completes), addr held until ready, then new pc requested.
//   Redirect same cycle as ready: returned data discarded. In HOLD: buffer dropped -> FETCH.
//  Priority: reset > redirect > stall > normal.
//  Stall (no redirect): pc frozen. STALL_MODE=0: instruc/nextpc/valid hold.
//   STALL_MODE=1: instruc<=NOP_WORD, valid<=0, nextpc<=pc_last.
//  Non-stall cycle with no instruction delivered: instruc<=NOP_WORD, valid<=0, nextpc holds.
//  PC arithmetic 32-bit, wraps 0xFFFFFFFC -> 0x00000000; address truncated to ADDR_W bits.
// TESTING
//  1. reset pulse, ready tied 1, data=addr -> en=1 from 2nd cycle; instr 0,4,8 delivered
//     on consecutive cycles, nextpc 4,8,0xC, valid=1.
//  2. ready delayed 3 cycles on pc=8 -> addr=8, en=1 held 3 cycles; valid=0, instruc=0 meanwhile;
//     then instr @8, nextpc=0xC.
//  3. redirect type 01 rega=0x100 while pc=0x10 awaiting ready -> data @0x10 discarded,
//     next request addr=0x100, first valid nextpc=0x104.
//  4. STALL_MODE=1, stall 2 cycles after delivering pc=0x20 -> instruc=0, valid=0,
//     nextpc=0x20 both cycles; then 0x24 fetched, no instruction lost or duplicated.
//  5. STALL_MODE=0, ready arrives during stall -> en=0 (HOLD), outputs unchanged;
//     stall drop delivers buffered word next cycle.
//  6. Redirect type 11 and stall same cycle -> pc=64; reset asserted mid-WAIT -> en=0,
//     pc=RESET_PC immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from a memory controller that may insert
// wait states, and delivers instruction / PC+4 / valid to decode under redirect and stall.
module fetch_unit #(
    parameter int unsigned ADDR_W     = 18,
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] EXC_VECTOR = 32'd64,
    parameter logic [31:0] NOP_WORD   = 32'd0,
    parameter bit          STALL_MODE = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_if_stall,
    input  logic              id_if_selpcsource,
    input  logic [1:0]        id_if_selpctype,
    input  logic [31:0]       id_if_pcimd2ext,
    input  logic [31:0]       id_if_rega,
    input  logic [31:0]       id_if_pcindex,
    output logic [31:0]       if_id_instruc,
    output logic [31:0]       if_id_nextpc,
    output logic              if_id_valid,
    output logic              if_mc_en,
    output logic [ADDR_W-1:0] if_mc_addr,
    input  logic [31:0]       mc_if_data,
    input  logic              mc_if_ready
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pc_last_q, pc_last_d;
    logic [XLEN-1:0]   redir_q, redir_d;
    logic [XLEN-1:0]   buf_q, buf_d;
    logic              kill_q, kill_d;
    logic              en_q, en_d;
    logic [XLEN-1:0]   instruc_q, instruc_d;
    logic [XLEN-1:0]   nextpc_q, nextpc_d;
    logic              valid_q, valid_d;

    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   pc_inc;
    logic [XLEN-1:0]   stall_instruc;
    logic [XLEN-1:0]   stall_nextpc;
    logic              stall_valid;

    assign pc_inc = pc_q + XLEN'(4);

    // The outstanding request keeps its address: a kill parks the new target in redir_q
    // instead of moving pc, so if_mc_addr stays stable until the memory answers.
    assign if_mc_addr    = pc_q[ADDR_W-1:0];
    assign if_mc_en      = en_q;
    assign if_id_instruc = instruc_q;
    assign if_id_nextpc  = nextpc_q;
    assign if_id_valid   = valid_q;

    always_comb begin
        target = id_if_pcimd2ext;
        case (id_if_selpctype)
            2'b00:   target = id_if_pcimd2ext;
            2'b01:   target = id_if_rega;
            2'b10:   target = id_if_pcindex;
            default: target = EXC_VECTOR;
        endcase
    end

    // Decode-facing values for a stalled cycle: either freeze or insert a bubble.
    always_comb begin
        stall_instruc = NOP_WORD;
        stall_valid   = 1'b0;
        stall_nextpc  = pc_last_q;
        if (STALL_MODE == 1'b0) begin
            stall_instruc = instruc_q;
            stall_valid   = valid_q;
            stall_nextpc  = nextpc_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_last_d = pc_last_q;
        redir_d   = redir_q;
        buf_d     = buf_q;
        kill_d    = kill_q;
        en_d      = en_q;
        instruc_d = NOP_WORD;
        nextpc_d  = nextpc_q;
        valid_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                en_d    = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (id_if_selpcsource) begin
                    if (mc_if_ready) begin
                        pc_d   = target;
                        kill_d = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                        redir_d = target;
                    end
                end else if (mc_if_ready && kill_q) begin
                    pc_d   = redir_q;
                    kill_d = 1'b0;
                    if (ex_if_stall) begin
                        instruc_d = stall_instruc;
                        valid_d   = stall_valid;
                        nextpc_d  = stall_nextpc;
                    end
                end else if (mc_if_ready && !ex_if_stall) begin
                    instruc_d = mc_if_data;
                    nextpc_d  = pc_inc;
                    valid_d   = 1'b1;
                    pc_last_d = pc_q;
                    pc_d      = pc_inc;
                end else if (mc_if_ready) begin
                    buf_d     = mc_if_data;
                    en_d      = 1'b0;
                    state_d   = ST_HOLD;
                    instruc_d = stall_instruc;
                    valid_d   = stall_valid;
                    nextpc_d  = stall_nextpc;
                end else if (ex_if_stall) begin
                    instruc_d = stall_instruc;
                    valid_d   = stall_valid;
                    nextpc_d  = stall_nextpc;
                end
            end
            ST_HOLD: begin
                if (id_if_selpcsource) begin
                    pc_d    = target;
                    en_d    = 1'b1;
                    state_d = ST_FETCH;
                end else if (!ex_if_stall) begin
                    instruc_d = buf_q;
                    nextpc_d  = pc_inc;
                    valid_d   = 1'b1;
                    pc_last_d = pc_q;
                    pc_d      = pc_inc;
                    en_d      = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    instruc_d = stall_instruc;
                    valid_d   = stall_valid;
                    nextpc_d  = stall_nextpc;
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            pc_last_q <= RESET_PC;
            redir_q   <= RESET_PC;
            buf_q     <= NOP_WORD;
            kill_q    <= 1'b0;
            en_q      <= 1'b0;
            instruc_q <= NOP_WORD;
            nextpc_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_last_q <= pc_last_d;
            redir_q   <= redir_d;
            buf_q     <= buf_d;
            kill_q    <= kill_d;
            en_q      <= en_d;
            instruc_q <= instruc_d;
            nextpc_q  <= nextpc_d;
            valid_q   <= valid_d;
        end
    end

endmodule
